// File: rtl/masked_mem_rd_stream.sv
// masked_mem_rd_stream: one-command line-read engine that realigns unaligned data into header+payload flits
module masked_mem_rd_stream #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int LEN_W = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BYTES = DATA_W / 8,
  localparam int OW = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_hdr,
  output logic              mem_rd_val,
  input  logic              mem_rd_rdy,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_resp_val,
  output logic              mem_resp_rdy,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [OW-1:0]     out_padbytes,
  output logic              rd_in_progress
);
  localparam int CW = LEN_W + 1;
  localparam int SW = CW + 1;
  localparam int NW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] hdr_q, hdr_d, prev_q, prev_d;
  logic [OW-1:0] off_q, off_d, pad_q, pad_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CW-1:0] lines_q, lines_d, flits_q, flits_d, issued_q, issued_d, rcvd_q, rcvd_d, sent_q, sent_d;
  logic [NW-1:0] outst_q, outst_d;
  logic [SW-1:0] span;
  logic [2*DATA_W-1:0] cat;
  logic [DATA_W-1:0] flit;
  logic rd_hs, resp_hs, out_hs, fin, last;
  always_comb begin
    cmd_rdy = state_q == IDLE;
    rd_in_progress = state_q != IDLE;
    mem_rd_val = rd_in_progress && issued_q < lines_q && outst_q < NW'(MAX_OUTSTANDING);
    mem_rd_addr = {addr_q[ADDR_W-1:OW], OW'(0)} + (ADDR_W'(issued_q) << OW);
    fin = rcvd_q == lines_q;
    last = state_q == STREAM && sent_q == flits_q - CW'(1);
    cat = {prev_q, fin ? {DATA_W{1'b0}} : mem_resp_data} << {off_q, 3'b000};
    flit = off_q == '0 ? mem_resp_data : cat[2*DATA_W-1 -: DATA_W];
    mem_resp_rdy = 1'b0;
    out_val = 1'b0;
    if (state_q == HDR) out_val = 1'b1;
    else if (state_q == STREAM) begin
      if (off_q == '0) begin
        out_val = mem_resp_val && !fin;
        mem_resp_rdy = out_rdy && !fin;
      end else if (rcvd_q == '0) mem_resp_rdy = 1'b1;
      else if (!fin) begin
        out_val = mem_resp_val;
        mem_resp_rdy = out_rdy;
      end else out_val = sent_q < flits_q;
    end
    out_last = state_q == HDR ? len_q == '0 : last;
    out_padbytes = last ? pad_q : '0;
    out_data = state_q == HDR ? hdr_q :
               state_q != STREAM ? '0 :
               last ? flit & ({DATA_W{1'b1}} << {pad_q, 3'b000}) : flit;
    rd_hs = mem_rd_val && mem_rd_rdy;
    resp_hs = mem_resp_val && mem_resp_rdy;
    out_hs = out_val && out_rdy;
    state_d = state_q;
    addr_d = addr_q;
    hdr_d = hdr_q;
    len_d = len_q;
    off_d = off_q;
    pad_d = pad_q;
    lines_d = lines_q;
    flits_d = flits_q;
    issued_d = issued_q + CW'(rd_hs);
    rcvd_d = rcvd_q + CW'(resp_hs);
    sent_d = sent_q + CW'(out_hs && state_q == STREAM);
    outst_d = outst_q + NW'(rd_hs) - NW'(resp_hs);
    prev_d = resp_hs ? mem_resp_data : prev_q;
    span = SW'(cmd_addr[OW-1:0]) + SW'(cmd_len) + SW'(BYTES - 1);
    if (state_q == IDLE && cmd_val) begin
      state_d = HDR;
      addr_d = cmd_addr;
      hdr_d = cmd_hdr;
      len_d = cmd_len;
      off_d = cmd_addr[OW-1:0];
      pad_d = -cmd_len[OW-1:0];
      lines_d = CW'(span >> OW);
      flits_d = CW'((CW'(cmd_len) + CW'(BYTES - 1)) >> OW);
      issued_d = '0;
      rcvd_d = '0;
      sent_d = '0;
      outst_d = '0;
    end
    if (state_q == HDR && out_hs) state_d = len_q == '0 ? IDLE : STREAM;
    if (out_hs && last) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      hdr_q <= '0;
      prev_q <= '0;
      len_q <= '0;
      off_q <= '0;
      pad_q <= '0;
      lines_q <= '0;
      flits_q <= '0;
      issued_q <= '0;
      rcvd_q <= '0;
      sent_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      hdr_q <= hdr_d;
      prev_q <= prev_d;
      len_q <= len_d;
      off_q <= off_d;
      pad_q <= pad_d;
      lines_q <= lines_d;
      flits_q <= flits_d;
      issued_q <= issued_d;
      rcvd_q <= rcvd_d;
      sent_q <= sent_d;
      outst_q <= outst_d;
    end
  end
endmodule

// File: tb/tb_masked_mem_rd_stream.sv
// tb_masked_mem_rd_stream: scoreboard bench with memory model, throttling and directed vectors
module tb_masked_mem_rd_stream;
  localparam int MAXO = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_val = 1'b0, cmd_rdy;
  logic [63:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [511:0] cmd_hdr = '0;
  logic mem_rd_val, mem_rd_rdy = 1'b0;
  logic [63:0] mem_rd_addr;
  logic mem_resp_val = 1'b0, mem_resp_rdy;
  logic [511:0] mem_resp_data = '0;
  logic out_val, out_rdy = 1'b0, out_last, rd_in_progress;
  logic [511:0] out_data;
  logic [5:0] out_padbytes;
  typedef struct {logic [511:0] d; logic last; logic [5:0] pad;} flit_t;
  typedef struct {logic [63:0] a; int len; int nrd; bit poke;} vec_t;
  flit_t exp_q[$];
  logic [63:0] eaddr[$], pend[$];
  int checks = 0, errors = 0, nrd = 0, outst = 0;
  bit thr = 0, resp_en = 1;
  always #5 clk = ~clk;
  masked_mem_rd_stream #(.DATA_W(512), .ADDR_W(64), .LEN_W(16), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_hdr(cmd_hdr), .mem_rd_val(mem_rd_val), .mem_rd_rdy(mem_rd_rdy),
    .mem_rd_addr(mem_rd_addr), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_data(mem_resp_data), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_last(out_last), .out_padbytes(out_padbytes), .rd_in_progress(rd_in_progress));
  function automatic logic [7:0] mb(logic [63:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction
  function automatic logic [511:0] line(logic [63:0] a);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[511-8*i -: 8] = mb(a + 64'(i));
    return l;
  endfunction
  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push_exp(logic [63:0] a, int len, logic [511:0] h);
    int nf, nl;
    flit_t f;
    f.d = h; f.last = len == 0; f.pad = 0;
    exp_q.push_back(f);
    nf = (len + 63) / 64;
    for (int k = 0; k < nf; k++) begin
      for (int j = 0; j < 64; j++) f.d[511-8*j -: 8] = (k*64 + j < len) ? mb(a + 64'(k*64 + j)) : 8'h00;
      f.last = k == nf - 1;
      f.pad = f.last ? 6'((64 - len % 64) % 64) : 6'd0;
      exp_q.push_back(f);
    end
    nl = (int'(a[5:0]) + len + 63) / 64;
    for (int i = 0; i < nl; i++) eaddr.push_back({a[63:6], 6'd0} + 64'(i*64));
  endtask
  task automatic issue(logic [63:0] a, int len, logic [511:0] h, bit poke);
    push_exp(a, len, h);
    chk("cmd_rdy_idle", cmd_rdy, 1);
    cmd_addr = a; cmd_len = 16'(len); cmd_hdr = h; cmd_val = 1'b1;
    @(posedge clk); #1;
    if (poke) begin
      cmd_addr = 64'h9999; cmd_len = 16'd64; cmd_hdr = '1;
      repeat (2) begin
        chk("cmd_rdy_busy", cmd_rdy, 0);
        @(posedge clk); #1;
      end
    end
    cmd_val = 1'b0;
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = !rd_in_progress && exp_q.size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: got %0d flits still expected, required 0", exp_q.size());
    end
  endtask
  task automatic run_cmd(logic [63:0] a, int len, int ereads, bit poke);
    int r0 = nrd;
    issue(a, len, {16{$urandom()}}, poke);
    wait_idle();
    chk("reads_issued", 512'(nrd - r0), 512'(ereads));
  endtask
  task automatic chk_rst();
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_mem_rd_val", mem_rd_val, 0);
    chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_padbytes", out_padbytes, 0);
    chk("rst_rd_in_progress", rd_in_progress, 0);
  endtask
  initial begin
    flit_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete(); eaddr.delete(); exp_q.delete(); outst = 0;
      end else begin
        if (mem_rd_val && mem_rd_rdy) begin
          if (eaddr.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_addr_extra: got read %0h, required none", mem_rd_addr);
          end else chk("rd_addr", mem_rd_addr, eaddr.pop_front());
          pend.push_back(mem_rd_addr);
          nrd++; outst++;
          chk("outstanding_over_max", outst > MAXO, 0);
        end
        if (mem_resp_val && mem_resp_rdy) begin
          void'(pend.pop_front());
          outst--;
        end
        if (out_val && out_rdy) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL flit_extra: got flit %0h, required none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("flit_data", out_data, e.d);
            chk("flit_last", out_last, e.last);
            chk("flit_pad", out_padbytes, e.pad);
          end
        end
      end
      @(posedge clk); #1;
      mem_rd_rdy = thr ? $urandom_range(0, 3) != 0 : 1'b1;
      out_rdy = thr ? $urandom_range(0, 3) != 0 : 1'b1;
      mem_resp_val = resp_en && pend.size() > 0 && (thr ? $urandom_range(0, 2) != 0 : 1'b1);
      mem_resp_data = pend.size() > 0 ? line(pend[0]) : '0;
    end
  end
  initial begin
    vec_t vecs[8] = '{
      '{64'h1000, 128, 2, 1'b0}, '{64'h1010, 100, 2, 1'b0}, '{64'h1000, 0, 0, 1'b0},
      '{64'h103F, 1, 1, 1'b0}, '{64'h1001, 64, 2, 1'b0}, '{64'h1020, 32, 1, 1'b0},
      '{64'h1000, 1, 1, 1'b0}, '{64'h3000, 640, 10, 1'b1}};
    int r0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst();
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      thr = p == 1;
      foreach (vecs[i]) run_cmd(vecs[i].a, vecs[i].len, vecs[i].nrd, vecs[i].poke);
    end
    thr = 0;
    resp_en = 0;
    r0 = nrd;
    issue(64'h2000, 640, {16{32'hA5A5_0001}}, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_reads", 512'(nrd - r0), 512'(2));
    chk("stall_flits_left", 512'(exp_q.size()), 512'(10));
    resp_en = 1;
    wait_idle();
    chk("stall_total_reads", 512'(nrd - r0), 512'(10));
    issue(64'h4000, 640, {16{32'h0BAD_F00D}}, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_rst();
    rst = 1'b0;
    @(negedge clk);
    run_cmd(64'h1010, 100, 2, 0);
    thr = 1;
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] a = 64'($urandom_range(0, 65535));
      int len = $urandom_range(0, 300);
      run_cmd(a, len, (int'(a[5:0]) + len + 63) / 64, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
